light_monitor: RTL and testbench
================================

# light_monitor

Receive-side checker for the traffic-light output interface. Samples the `R`/`G`/`Y` lamp lines driven by the light datapath, measures how long each lamp pattern is held, and checks the full G1 → off → G2 → off → G3 → Y → R phase sequence against programmed durations. It reports lock, the current phase, completed cycles and protocol errors. It sits beside the light controller in the top level and in the bench as a passive observer.

## Interface

**Parameters**
- `CNT_W`, default 12: run-length counter width. Must hold `LEN_G1+TOL` and `LEN_R+TOL`.
- `LEN_G1`, default 1024: expected cycles of the first green.
- `LEN_SHORT`, default 128: expected cycles of off1, G2, off2 and G3.
- `LEN_Y`, default 512: expected cycles of yellow.
- `LEN_R`, default 1024: expected cycles of red.
- `TOL`, default 2: allowed ± deviation on every run length.

**Ports**
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `R`, `G`, `Y` input 1 each: lamp lines. They form `in = {R,G,Y}`.
- `phase` output 3: expected-phase state.
- `locked` output 1: high when `phase != SYNC`.
- `run_len` output `CNT_W`: cycles the current sampled pattern has been held. Saturates at all-ones.
- `err` output 1: one-cycle error pulse.
- `err_code` output 3: cause of the most recent error. Held until the next error.
- `cyc_done` output 1: one-cycle pulse per completed legal cycle.
- `cyc_cnt` output 8: completed-cycle count. Wraps 255 → 0.

## Operation

**Pattern encoding**
- Legal `in` values: 100 = red, 010 = green, 001 = yellow, 000 = off.
- Any other value is illegal.

**Sampling and run length**
- Sample register `s_q` holds the last value of `in`.
- `edge` = (`in != s_q`).
- On `edge`:
  - The run of `s_q` just completed; its length is `run_len`.
  - `s_q <= in`, `run_len <= 1`.
- Otherwise `run_len <= run_len + 1`, saturating.

**Phase state machine**
- States and codes:
  - 0 SYNC
  - 1 G1 (green, `LEN_G1`)
  - 2 OFF1 (off, `LEN_SHORT`)
  - 3 G2 (green, `LEN_SHORT`)
  - 4 OFF2 (off, `LEN_SHORT`)
  - 5 G3 (green, `LEN_SHORT`)
  - 6 Y (yellow, `LEN_Y`)
  - 7 R (red, `LEN_R`)
- Transitions:
  - SYNC → G1 on `edge` with `s_q == 100` and `in == 010`. No length check is made on this first red run.
  - Every other state: on `edge`, the completed run must have the state's colour and a length in [EXP−TOL, EXP+TOL]. The new `in` must be the next state's colour. If so, advance to the next state.
  - R → G1 also pulses `cyc_done` and increments `cyc_cnt`.

**Error codes and priority** (highest first)
- 1 ILLEGAL: `in` is an illegal value. Checked in every state, including SYNC.
- 4 LONG: no `edge` and `run_len + 1 > EXP+TOL`, outside SYNC. Flagged on the cycle the run would exceed the maximum; the run does not have to end first.
- 3 SHORT: on `edge`, `run_len < EXP−TOL`.
- 2 SEQ: on `edge`, the new `in` is the wrong colour for the next state.

**Error response**
- `err` pulses for one cycle and `err_code` is loaded.
- FSM → SYNC.
- `run_len` and `s_q` keep updating normally.
- `cyc_cnt` is not cleared.

## Timing

- **Reset (`rst` low):**
  - `s_q` = 000, `run_len` = 0.
  - `phase` = 0, `locked` = 0.
  - `err` = 0, `err_code` = 0.
  - `cyc_done` = 0, `cyc_cnt` = 0.
  - Takes effect immediately, mid-run or mid-cycle. After release the block restarts in SYNC.
- **Latency:** all outputs are registered. A change of `in` sampled at rising edge k is reflected after edge k:
  - `err`, `cyc_done`, `phase` and `run_len == 1` are valid in cycle k+1.
- **Pulse width:** `err` and `cyc_done` are exactly one cycle wide.
- **Simultaneous edge and error:** only the highest-priority code is reported; one pulse.
- **R run failing at R → G:** `cyc_done` is not asserted and `cyc_cnt` is unchanged.
- **SYNC → G1 transition:** never asserts `cyc_done`.
- **Cycle counter wrap:** 255 + 1 → 0, with `cyc_done` still pulsed.
- **Saturation:** `run_len` holds at 2^CNT_W − 1. No error is raised in SYNC.

## Test plan

- **Reset:** drive `rst` low mid-G2 of a locked cycle → all outputs 0 asynchronously. After release, `locked` stays 0 until the next R → G.
- **Nominal:** red 1024, then G 1024, off 128, G 128, off 128, G 128, Y 512, R 1024, G
  - `locked` rises after the first R → G.
  - One `cyc_done` at the second R → G; `cyc_cnt` = 1.
  - `err` never asserts.
  - `phase` steps through 1..7 with one-cycle latency.
- **Short yellow:** Y held 509 cycles (min 510) → `err` one cycle, `err_code` = 3, `phase` = 0.
- **Long green:** G1 held → `err` at the cycle `run_len` would reach 1027, `err_code` = 4, before the run ends.
- **Illegal value and wrong sequence:**
  - {R,G,Y} = 110 for one cycle → `err_code` = 1.
  - In a separate run, G1 1024 then Y directly → `err_code` = 2.
- **Counter wrap:** 256 nominal cycles → `cyc_cnt` wraps 255 → 0, and `cyc_done` pulses on the wrapping cycle.

Source files
------------

// File: rtl/light_monitor.sv
// Passive checker for the R/G/Y lamp lines: measures run lengths and
// tracks the G1-off-G2-off-G3-Y-R phase sequence against programmed durations.
module light_monitor #(
  parameter int CNT_W     = 12,
  parameter int LEN_G1    = 1024,
  parameter int LEN_SHORT = 128,
  parameter int LEN_Y     = 512,
  parameter int LEN_R     = 1024,
  parameter int TOL       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             R,
  input  logic             G,
  input  logic             Y,
  output logic [2:0]       phase,
  output logic             locked,
  output logic [CNT_W-1:0] run_len,
  output logic             err,
  output logic [2:0]       err_code,
  output logic             cyc_done,
  output logic [7:0]       cyc_cnt
);

  localparam int W1 = CNT_W + 1;

  localparam logic [2:0] C_RED = 3'b100;
  localparam logic [2:0] C_GRN = 3'b010;
  localparam logic [2:0] C_YEL = 3'b001;
  localparam logic [2:0] C_OFF = 3'b000;

  localparam logic [2:0] E_ILL  = 3'd1;
  localparam logic [2:0] E_SEQ  = 3'd2;
  localparam logic [2:0] E_SHRT = 3'd3;
  localparam logic [2:0] E_LONG = 3'd4;

  typedef enum logic [2:0] {
    P_SYNC, P_G1, P_OFF1, P_G2,
    P_OFF2, P_G3, P_Y, P_R
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [2:0]       s_q, s_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic             done_q, done_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [2:0]  in_w;
  logic        edge_w;
  logic        illegal;
  logic [W1-1:0] lo, hi;
  logic [W1-1:0] run_inc;
  logic [2:0]  col, nxt_col;
  phase_e      nxt;
  logic [2:0]  code_e;

  assign in_w    = {R, G, Y};
  assign edge_w  = (in_w != s_q);
  assign illegal = !(in_w == C_RED || in_w == C_GRN ||
                     in_w == C_YEL || in_w == C_OFF);
  assign run_inc = {1'b0, run_q} + W1'(1);

  // Expected colour and length window of the current phase, and its successor.
  always_comb begin
    lo      = '0;
    hi      = '0;
    col     = C_OFF;
    nxt     = P_SYNC;
    nxt_col = C_OFF;
    unique case (phase_q)
      P_SYNC: begin
        nxt = P_G1; nxt_col = C_GRN;
      end
      P_G1: begin
        lo = W1'(LEN_G1 - TOL); hi = W1'(LEN_G1 + TOL);
        col = C_GRN; nxt = P_OFF1; nxt_col = C_OFF;
      end
      P_OFF1: begin
        lo = W1'(LEN_SHORT - TOL); hi = W1'(LEN_SHORT + TOL);
        col = C_OFF; nxt = P_G2; nxt_col = C_GRN;
      end
      P_G2: begin
        lo = W1'(LEN_SHORT - TOL); hi = W1'(LEN_SHORT + TOL);
        col = C_GRN; nxt = P_OFF2; nxt_col = C_OFF;
      end
      P_OFF2: begin
        lo = W1'(LEN_SHORT - TOL); hi = W1'(LEN_SHORT + TOL);
        col = C_OFF; nxt = P_G3; nxt_col = C_GRN;
      end
      P_G3: begin
        lo = W1'(LEN_SHORT - TOL); hi = W1'(LEN_SHORT + TOL);
        col = C_GRN; nxt = P_Y; nxt_col = C_YEL;
      end
      P_Y: begin
        lo = W1'(LEN_Y - TOL); hi = W1'(LEN_Y + TOL);
        col = C_YEL; nxt = P_R; nxt_col = C_RED;
      end
      P_R: begin
        lo = W1'(LEN_R - TOL); hi = W1'(LEN_R + TOL);
        col = C_RED; nxt = P_G1; nxt_col = C_GRN;
      end
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    s_d     = in_w;
    err_d   = 1'b0;
    code_d  = code_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    code_e  = 3'd0;
    if (edge_w)
      run_d = CNT_W'(1);
    else if (&run_q)
      run_d = run_q;
    else
      run_d = run_q + CNT_W'(1);

    // Priority: illegal, then long, then short, then sequence.
    if (illegal) begin
      code_e = E_ILL;
    end else if (phase_q == P_SYNC) begin
      if (edge_w && s_q == C_RED && in_w == C_GRN)
        phase_d = P_G1;
    end else if (!edge_w) begin
      if (run_inc > hi)
        code_e = E_LONG;
    end else if ({1'b0, run_q} < lo) begin
      code_e = E_SHRT;
    end else if (s_q != col || in_w != nxt_col) begin
      code_e = E_SEQ;
    end else begin
      phase_d = nxt;
      if (phase_q == P_R) begin
        done_d = 1'b1;
        cnt_d  = cnt_q + 8'd1;
      end
    end

    if (code_e != 3'd0) begin
      err_d   = 1'b1;
      code_d  = code_e;
      phase_d = P_SYNC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= P_SYNC;
      s_q     <= C_OFF;
      run_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      phase_q <= phase_d;
      s_q     <= s_d;
      run_q   <= run_d;
      err_q   <= err_d;
      code_q  <= code_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase    = phase_q;
  assign locked   = (phase_q != P_SYNC);
  assign run_len  = run_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign cyc_done = done_q;
  assign cyc_cnt  = cnt_q;

endmodule

// File: tb/tb_light_monitor.sv
// Randomized bench for light_monitor: drives lamp runs and compares every
// output each cycle against a phase-table reference model.
module tb_light_monitor;

  localparam int CW   = 8;
  localparam int LG1  = 16;
  localparam int LS   = 4;
  localparam int LY   = 8;
  localparam int LR   = 16;
  localparam int TOL  = 2;
  localparam int RMAX = (1 << CW) - 1;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] GRN = 3'b010;
  localparam logic [2:0] YEL = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic          clk = 1'b0;
  logic          rst;
  logic          R, G, Y;
  logic [2:0]    phase;
  logic          locked;
  logic [CW-1:0] run_len;
  logic          err;
  logic [2:0]    err_code;
  logic          cyc_done;
  logic [7:0]    cyc_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // phase table: index 1..7 = G1, OFF1, G2, OFF2, G3, Y, R
  int pcol [8];
  int plen [8];

  int m_s, m_run, m_ph, m_err, m_code, m_done, m_cnt;

  always #5 clk = ~clk;

  light_monitor #(
    .CNT_W(CW), .LEN_G1(LG1), .LEN_SHORT(LS),
    .LEN_Y(LY), .LEN_R(LR), .TOL(TOL)
  ) dut (
    .clk(clk), .rst(rst),
    .R(R), .G(G), .Y(Y),
    .phase(phase), .locked(locked),
    .run_len(run_len), .err(err),
    .err_code(err_code), .cyc_done(cyc_done),
    .cyc_cnt(cyc_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_s = 0; m_run = 0; m_ph = 0;
    m_err = 0; m_code = 0; m_done = 0; m_cnt = 0;
  endtask

  // Reference: one sampled value of {R,G,Y} applied to the phase table.
  task automatic m_step(input int v);
    int nph, nx, code;
    bit e, legal;
    e     = (v != m_s);
    legal = (v == 0 || v == 1 || v == 2 || v == 4);
    nph   = m_ph;
    nx    = (m_ph == 7) ? 1 : m_ph + 1;
    code  = 0;
    m_done = 0;
    if (!legal) code = 1;
    else if (m_ph == 0) begin
      if (e && m_s == 4 && v == 2) nph = 1;
    end else if (!e) begin
      if (m_run + 1 > plen[m_ph] + TOL) code = 4;
    end else if (m_run < plen[m_ph] - TOL) code = 3;
    else if (v != pcol[nx]) code = 2;
    else begin
      nph = nx;
      if (m_ph == 7) begin
        m_done = 1;
        m_cnt = (m_cnt + 1) % 256;
      end
    end
    m_err = (code != 0);
    if (code != 0) begin
      m_code = code;
      nph = 0;
    end
    m_ph = nph;
    if (e) m_run = 1;
    else if (m_run < RMAX) m_run = m_run + 1;
    m_s = v;
  endtask

  task automatic cmp_all();
    chk("phase", int'(phase), m_ph);
    chk("locked", int'(locked), int'(m_ph != 0));
    chk("run_len", int'(run_len), m_run);
    chk("err", int'(err), m_err);
    chk("err_code", int'(err_code), m_code);
    chk("cyc_done", int'(cyc_done), m_done);
    chk("cyc_cnt", int'(cyc_cnt), m_cnt);
  endtask

  task automatic cyc(input logic [2:0] v);
    {R, G, Y} = v;
    m_step(int'(v));
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic run(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) cyc(v);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_phase"}, int'(phase), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_run"}, int'(run_len), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_code"}, int'(err_code), 0);
    chk({tag, "_done"}, int'(cyc_done), 0);
    chk({tag, "_cnt"}, int'(cyc_cnt), 0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    zero_check("rst");
    {R, G, Y} = OFF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    m_reset();
  endtask

  function automatic int jit();
    return int'($urandom_range(0, 2 * TOL)) - TOL;
  endfunction

  task automatic full_cycle(input bit j);
    for (int p = 1; p < 8; p++)
      run(3'(pcol[p]), plen[p] + (j ? jit() : 0));
  endtask

  task automatic rand_cycle();
    int len, r, c;
    int ill [4];
    ill = '{3, 5, 6, 7};
    for (int p = 1; p < 8; p++) begin
      c   = pcol[p];
      len = plen[p] + jit();
      r   = int'($urandom_range(0, 99));
      if (r < 4) len = plen[p] - TOL - 1 - int'($urandom_range(0, 1));
      else if (r < 8) len = plen[p] + TOL + 1 + int'($urandom_range(0, 2));
      else if (r < 11) c = int'($urandom_range(0, 4));
      else if (r < 13) cyc(3'(ill[$urandom_range(0, 3)]));
      if (len < 1) len = 1;
      run(3'(c), len);
    end
  endtask

  initial begin
    pcol = '{0, 2, 0, 2, 0, 2, 1, 4};
    plen = '{0, LG1, LS, LS, LS, LS, LY, LR};
    m_reset();
    rst = 1'b0;
    {R, G, Y} = OFF;
    repeat (2) @(posedge clk);
    #1;
    zero_check("init");
    rst = 1'b1;

    // nominal: red, two cycles, closing green
    run(RED, LR);
    full_cycle(0);
    full_cycle(0);
    run(GRN, 2);
    chk("nom_cnt", int'(cyc_cnt), 2);

    // reset in the middle of G2 of a locked cycle
    do_reset();
    run(RED, LR);
    full_cycle(0);
    run(GRN, LG1); run(OFF, LS); run(GRN, 2);
    do_reset();
    run(GRN, LS - 2); run(OFF, LS); run(GRN, LS);
    run(YEL, LY); run(RED, LR); run(GRN, 2);
    chk("post_rst_lock", int'(locked), 1);
    chk("post_rst_cnt", int'(cyc_cnt), 0);

    // short yellow
    do_reset();
    run(RED, LR);
    run(GRN, LG1); run(OFF, LS); run(GRN, LS);
    run(OFF, LS); run(GRN, LS); run(YEL, LY - TOL - 1);
    run(RED, 3);
    chk("short_code", int'(err_code), 3);

    // long green, flagged before the run ends
    do_reset();
    run(RED, LR);
    run(GRN, LG1 + TOL + 4);
    chk("long_code", int'(err_code), 4);

    // illegal value
    do_reset();
    run(RED, LR);
    run(GRN, 5);
    cyc(3'b110);
    run(GRN, 3);
    chk("ill_code", int'(err_code), 1);

    // wrong sequence
    do_reset();
    run(RED, LR);
    run(GRN, LG1);
    run(YEL, 5);
    chk("seq_code", int'(err_code), 2);

    // randomized runs with occasional faults
    do_reset();
    run(RED, LR);
    for (int k = 0; k < 40; k++) rand_cycle();

    // counter wrap
    do_reset();
    run(RED, LR);
    for (int k = 0; k < 256; k++) full_cycle(1);
    run(GRN, 1);
    chk("wrap_done", int'(cyc_done), 1);
    chk("wrap_cnt", int'(cyc_cnt), 0);

    // run length saturation in SYNC
    do_reset();
    run(OFF, RMAX + 40);
    chk("sat_run", int'(run_len), RMAX);
    chk("sat_err", int'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
